segment_locator: RTL and testbench

- Parametrised, sequential successor to the single-range comparator used by the sigmoid/tanh approximators.
- Holds a programmable table of NSEG+1 breakpoints and, for each input sample, finds the segment k with bp[k] <= |x| < bp[k+1] by binary search.
- Returns the segment index, out-of-range flags and the input sign to the piecewise coefficient lookup, using valid/ready handshakes on both sides.

---
 rtl/segment_locator_if.sv | 32 +++
 rtl/segment_locator.sv | 162 ++++++++++++++++
 tb/tb_segment_locator.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/segment_locator_if.sv
// Sample/result stream bundle for segment_locator.
//
// Handshake rule for both directions: a transfer happens on the rising clk
// edge where valid and ready are both 1. The sender keeps valid and its data
// stable until that edge; ready may rise and fall freely and never waits on
// valid.
interface segment_locator_if #(
    parameter int xDW = 16,
    parameter int IW  = 3
);
    logic           in_valid;
    logic           in_ready;
    logic [xDW-1:0] x;
    logic           out_valid;
    logic           out_ready;
    logic [IW-1:0]  seg_idx;
    logic           below;
    logic           above;
    logic           sign;

    // Producer of samples / consumer of results.
    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, seg_idx, below, above, sign
    );

    // The locator itself.
    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, seg_idx, below, above, sign
    );
endinterface

// File: rtl/segment_locator.sv
// Sequential breakpoint locator: finds k with bp[k] <= |x| < bp[k+1] by a
// fixed-length binary search over a programmable table of NSEG+1 breakpoints.
// Flow: IDLE (accept) -> SEARCH (IW cycles) -> DONE (hold until taken).
module segment_locator #(
    parameter int xDW       = 16,
    parameter int NSEG      = 8,
    parameter int SIGNED_IN = 1,
    localparam int IW       = $clog2(NSEG),
    localparam int AW       = $clog2(NSEG + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    segment_locator_if.slave   s,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [xDW-1:0]     cfg_data,
    output logic               cfg_ready,
    output logic [1:0]         dbg_state
);

    localparam int CW = (IW < 1) ? 1 : $clog2(IW + 1);
    localparam logic [xDW-1:0] MOST_NEG = {1'b1, {(xDW-1){1'b0}}};
    localparam logic [xDW-1:0] MOST_POS = {1'b0, {(xDW-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [xDW-1:0] bp [NSEG+1];
    logic [xDW-1:0] xabs, xabs_in;
    logic           sign_in, sign_q, below_q, above_q;
    logic [AW-1:0]  lo, hi, mid, lo_nxt, hi_nxt;
    logic [AW:0]    lo_hi_sum;
    logic [CW-1:0]  step;
    logic [IW-1:0]  seg_q;
    logic           in_ready_int, out_valid_int, cfg_ready_int;
    logic           accept, last_step;

    assign accept    = s.in_valid & in_ready_int;
    assign last_step = (step == CW'(IW - 1));

    // Magnitude of the incoming sample; the most negative code saturates.
    always_comb begin
        sign_in = 1'b0;
        xabs_in = s.x;
        if (SIGNED_IN != 0 && s.x[xDW-1]) begin
            sign_in = 1'b1;
            if (s.x == MOST_NEG) xabs_in = MOST_POS;
            else                 xabs_in = -s.x;
        end
    end

    // One binary-search step; once the window is a single segment it holds.
    always_comb begin
        lo_hi_sum = {1'b0, lo} + {1'b0, hi};
        mid       = AW'(lo_hi_sum >> 1);
        lo_nxt    = lo;
        hi_nxt    = hi;
        if ((hi - lo) > AW'(1)) begin
            if (xabs >= bp[mid]) lo_nxt = mid;
            else                 hi_nxt = mid;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state and handshake outputs; en=0 forces IDLE from anywhere.
    always_comb begin
        state_nxt     = state;
        in_ready_int  = 1'b0;
        out_valid_int = 1'b0;
        cfg_ready_int = 1'b0;
        case (state)
            IDLE: begin
                in_ready_int  = en;
                cfg_ready_int = 1'b1;
                if (accept) state_nxt = SEARCH;
            end
            SEARCH: begin
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                out_valid_int = en;
                if (s.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!en) state_nxt = IDLE;
    end

    // Search datapath: capture at accept, narrow lo/hi, register the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xabs    <= '0;
            sign_q  <= 1'b0;
            below_q <= 1'b0;
            above_q <= 1'b0;
            lo      <= '0;
            hi      <= '0;
            step    <= '0;
            seg_q   <= '0;
        end else if (!en) begin
            sign_q  <= 1'b0;
            below_q <= 1'b0;
            above_q <= 1'b0;
            seg_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        xabs    <= xabs_in;
                        sign_q  <= sign_in;
                        below_q <= (xabs_in < bp[0]);
                        above_q <= (xabs_in >= bp[NSEG]);
                        lo      <= '0;
                        hi      <= AW'(NSEG);
                        step    <= '0;
                        seg_q   <= '0;
                    end
                end
                SEARCH: begin
                    lo   <= lo_nxt;
                    hi   <= hi_nxt;
                    step <= step + CW'(1);
                    if (last_step) begin
                        if (below_q)      seg_q <= '0;
                        else if (above_q) seg_q <= IW'(NSEG - 1);
                        else              seg_q <= lo_nxt[IW-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Breakpoint table; writes only land while the FSM is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NSEG; k++) bp[k] <= '0;
        end else if (cfg_we && cfg_ready_int && (cfg_addr <= AW'(NSEG))) begin
            bp[cfg_addr] <= cfg_data;
        end
    end

    assign s.in_ready  = in_ready_int;
    assign s.out_valid = out_valid_int;
    assign s.seg_idx   = out_valid_int ? seg_q   : '0;
    assign s.below     = out_valid_int ? below_q : 1'b0;
    assign s.above     = out_valid_int ? above_q : 1'b0;
    assign s.sign      = out_valid_int ? sign_q  : 1'b0;
    assign cfg_ready   = cfg_ready_int;
    assign dbg_state   = state;

endmodule

// File: tb/tb_segment_locator.sv
// Directed bench for segment_locator (xDW=16, NSEG=8). A signed instance and
// an unsigned instance run in lockstep on the same stimulus and table.
module tb_segment_locator;

    localparam int XW = 16;
    localparam int NS = 8;
    localparam int LAT = 4;   // accept cycle is cycle 0, out_valid in cycle IW+1

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [XW-1:0] cfg_data = '0;
    logic        cfg_ready1, cfg_ready0;
    logic [1:0]  dbg1, dbg0;

    int n_tests = 0;
    int n_fail  = 0;

    segment_locator_if #(.xDW(XW), .IW(3)) sif1 ();
    segment_locator_if #(.xDW(XW), .IW(3)) sif0 ();

    segment_locator #(.xDW(XW), .NSEG(NS), .SIGNED_IN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .s(sif1),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready1), .dbg_state(dbg1)
    );

    segment_locator #(.xDW(XW), .NSEG(NS), .SIGNED_IN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .s(sif0),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready0), .dbg_state(dbg0)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] x;
        logic [2:0]    seg;
        logic          below;
        logic          above;
        logic          sign;
        logic [2:0]    u_seg;
        logic          u_below;
        logic          u_above;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [XW-1:0] xv);
        sif1.in_valid = v; sif1.x = xv;
        sif0.in_valid = v; sif0.x = xv;
    endtask

    task automatic set_ordy(input logic r);
        sif1.out_ready = r;
        sif0.out_ready = r;
    endtask

    task automatic write_bp(input int a, input logic [XW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a[3:0]; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic accept(input logic [XW-1:0] xv);
        int n;
        n = 0;
        set_in(1'b1, xv);
        while (sif1.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: in_ready stayed %0d, required 1", sif1.in_ready);
        end
        tick();
        set_in(1'b0, '0);
    endtask

    // Call right after accept(); returns the cycle number of out_valid.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (sif1.out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic release_out();
        set_ordy(1'b1);
        tick();
        set_ordy(1'b0);
    endtask

    initial begin
        int cyc;
        logic saw_valid;

        //                 x        seg   bel   abv   sgn   useg  ubel  uabv
        vecs[0]  = '{16'd1500,  3'd2, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
        vecs[1]  = '{16'd512,   3'd1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
        vecs[2]  = '{16'd511,   3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{16'd4096,  3'd7, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b1};
        vecs[4]  = '{16'd4095,  3'd7, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0};
        vecs[5]  = '{16'd0,     3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{16'd3000,  3'd5, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0};
        vecs[7]  = '{16'd2048,  3'd4, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0};
        vecs[8]  = '{16'hFA24,  3'd2, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1};
        vecs[9]  = '{16'h8000,  3'd7, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b1};
        vecs[10] = '{16'hFFFF,  3'd0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 1'b1};
        vecs[11] = '{16'h7FFF,  3'd7, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b1};

        set_in(1'b0, '0);
        set_ordy(1'b0);

        // reset state
        repeat (3) tick();
        check("rst out_valid", sif1.out_valid, 0);
        check("rst seg_idx", sif1.seg_idx, 0);
        check("rst flags", {sif1.below, sif1.above, sif1.sign}, 0);
        check("rst cfg_ready", cfg_ready1, 1);
        check("rst state", dbg1, 0);
        rst_n = 1'b1;
        tick();
        check("idle in_ready", sif1.in_ready, 1);

        for (int k = 0; k <= NS; k++) write_bp(k, XW'(512 * k));

        // table-driven vectors
        for (int i = 0; i < 12; i++) begin
            accept(vecs[i].x);
            wait_done(cyc);
            check($sformatf("v%0d latency", i), cyc, LAT);
            check($sformatf("v%0d seg", i), sif1.seg_idx, vecs[i].seg);
            check($sformatf("v%0d below", i), sif1.below, vecs[i].below);
            check($sformatf("v%0d above", i), sif1.above, vecs[i].above);
            check($sformatf("v%0d sign", i), sif1.sign, vecs[i].sign);
            check($sformatf("v%0d u_valid", i), sif0.out_valid, 1);
            check($sformatf("v%0d u_seg", i), sif0.seg_idx, vecs[i].u_seg);
            check($sformatf("v%0d u_flags", i), {sif0.below, sif0.above},
                  {vecs[i].u_below, vecs[i].u_above});
            check($sformatf("v%0d u_sign", i), sif0.sign, 0);
            release_out();
            check($sformatf("v%0d idle after take", i), sif1.in_ready, 1);
        end

        // bp[0] write in the accept cycle: that sample still sees bp[0]=0
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'd100;
        set_in(1'b1, 16'd50);
        tick();
        cfg_we = 1'b0;
        set_in(1'b0, '0);
        wait_done(cyc);
        check("same-cycle wr below", sif1.below, 0);
        check("same-cycle wr seg", sif1.seg_idx, 0);
        release_out();

        // bp[0]=100 now: x=50 is below; hold the result for 5 cycles
        accept(16'd50);
        wait_done(cyc);
        check("below flag", sif1.below, 1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold%0d valid", c), sif1.out_valid, 1);
            check($sformatf("hold%0d seg", c), sif1.seg_idx, 0);
            check($sformatf("hold%0d below", c), sif1.below, 1);
            check($sformatf("hold%0d in_ready", c), sif1.in_ready, 0);
            tick();
        end
        release_out();
        check("post-hold in_ready", sif1.in_ready, 1);
        check("post-hold out_valid", sif1.out_valid, 0);
        write_bp(0, 16'd0);

        // reprogram bp[3] in IDLE
        write_bp(3, 16'd2000);
        accept(16'd1800);
        wait_done(cyc);
        check("bp3=2000 seg", sif1.seg_idx, 2);
        release_out();

        // write during SEARCH is dropped
        accept(16'd1800);
        tick();
        check("search cfg_ready", cfg_ready1, 0);
        cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 16'd1700;
        tick();
        cfg_we = 1'b0;
        wait_done(cyc);
        release_out();
        accept(16'd1800);
        wait_done(cyc);
        check("dropped wr seg", sif1.seg_idx, 2);
        release_out();
        write_bp(3, 16'd1536);
        accept(16'd1800);
        wait_done(cyc);
        check("bp3 restored seg", sif1.seg_idx, 3);
        release_out();

        // en=0 two cycles into SEARCH
        accept(16'd1500);
        tick();
        en = 1'b0;
        #1;
        check("en0 out_valid", sif1.out_valid, 0);
        check("en0 in_ready", sif1.in_ready, 0);
        tick();
        check("en0 state idle", dbg1, 0);
        tick();
        en = 1'b1;
        #1;
        check("en1 in_ready", sif1.in_ready, 1);
        accept(16'd1500);
        wait_done(cyc);
        check("after en latency", cyc, LAT);
        check("after en seg", sif1.seg_idx, 2);

        // en=0 while holding a result
        en = 1'b0;
        #1;
        check("en0 done valid", sif1.out_valid, 0);
        check("en0 done seg", sif1.seg_idx, 0);
        tick();
        en = 1'b1;
        #1;
        check("en0 done -> idle", dbg1, 0);

        // reset two cycles into SEARCH
        accept(16'd1500);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst mid state", dbg1, 0);
        check("rst mid valid", sif1.out_valid, 0);
        check("rst mid outs", {sif1.seg_idx, sif1.below, sif1.above, sif1.sign}, 0);
        tick();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (sif1.out_valid === 1'b1) saw_valid = 1'b1;
            tick();
        end
        check("rst no partial result", saw_valid, 0);

        // reset cleared the table: every breakpoint is 0, so 1500 is above
        accept(16'd1500);
        wait_done(cyc);
        check("cleared tbl above", sif1.above, 1);
        check("cleared tbl seg", sif1.seg_idx, 7);
        check("cleared tbl below", sif1.below, 0);
        release_out();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
